// File: rtl/csr_commit_ctrl_pkg.sv
// Shared definitions for the writeback commit controller and the csr block:
// CSR numbers, exception codes, FSM encoding and the commit-event index map.
package csr_commit_ctrl_pkg;

   localparam logic [13:0] CSR_CRMD   = 14'h000;
   localparam logic [13:0] CSR_ECFG   = 14'h004;
   localparam logic [13:0] CSR_ESTAT  = 14'h005;
   localparam logic [13:0] CSR_ERA    = 14'h006;
   localparam logic [13:0] CSR_EENTRY = 14'h00C;
   localparam logic [13:0] CSR_TICLR  = 14'h044;

   localparam logic [5:0] ECODE_INT     = 6'h00;
   localparam logic [5:0] ECODE_ADE     = 6'h08;
   localparam logic [5:0] ECODE_ALE     = 6'h09;
   localparam logic [8:0] ESUBCODE_ADEF = 9'h000;

   typedef enum logic {
      ST_RUN   = 1'b0,
      ST_REDIR = 1'b1
   } cc_state_e;

   // Bit positions inside the one-hot commit event vector.
   localparam int EV_INT   = 0;
   localparam int EV_EXC   = 1;
   localparam int EV_ERTN  = 2;
   localparam int EV_CSR   = 3;
   localparam int EV_PLAIN = 4;
   localparam int EV_W     = 5;

   // CSRs whose update can change fetch behaviour, so younger instructions must refetch.
   function automatic logic is_refetch_csr(input logic [13:0] num);
      logic hit;
      case (num)
         CSR_CRMD, CSR_ECFG, CSR_ESTAT, CSR_TICLR: hit = 1'b1;
         default:                                  hit = 1'b0;
      endcase
      return hit;
   endfunction

endpackage

// File: rtl/csr_commit_ctrl_chk.sv
// Protocol checker for the commit controller outputs.
module csr_commit_ctrl_chk (
   input logic        clk,
   input logic        resetn,
   input logic        csr_we,
   input logic        wb_ex,
   input logic        ertn_flush,
   input logic        commit,
   input logic        flush,
   input logic        redirect_valid,
   input logic        redirect_ready,
   input logic [31:0] redirect_pc
);

   a_csr_side_onehot: assert property (@(posedge clk) disable iff (!resetn)
      $onehot0({csr_we, wb_ex, ertn_flush}));

   a_quiet_in_redir: assert property (@(posedge clk) disable iff (!resetn)
      redirect_valid |-> !(csr_we | wb_ex | ertn_flush | commit | flush));

   a_redir_hold: assert property (@(posedge clk) disable iff (!resetn)
      (redirect_valid && !redirect_ready) |=> (redirect_valid && $stable(redirect_pc)));

   a_flush_redirects: assert property (@(posedge clk) disable iff (!resetn)
      flush |=> redirect_valid);

endmodule

// File: rtl/csr_commit_ctrl_prio.sv
// Fixed-priority encoder for writeback events: returns a one-hot event,
// whether it redirects the pipeline, and the redirect target.
module commit_prio
   import csr_commit_ctrl_pkg::*;
#(
   parameter bit REFETCH_ON_CSR = 1'b1
) (
   input  logic            active,
   input  logic            has_int,
   input  logic            ex_req,
   input  logic            is_ertn,
   input  logic            csr_wr,
   input  logic [13:0]     csr_num,
   input  logic [31:0]     pc,
   input  logic [31:0]     ex_entry,
   input  logic [31:0]     ertn_entry,
   output logic [EV_W-1:0] event_oh,
   output logic            redirect,
   output logic [31:0]     target
);

   // Priority selection: interrupt > exception > ertn > CSR write > plain commit.
   always_comb begin
      event_oh = {EV_W{1'b0}};
      redirect = 1'b0;
      target   = 32'd0;
      if (!active) begin
         event_oh = {EV_W{1'b0}};
      end else if (has_int) begin
         event_oh[EV_INT] = 1'b1;
         redirect         = 1'b1;
         target           = ex_entry;
      end else if (ex_req) begin
         event_oh[EV_EXC] = 1'b1;
         redirect         = 1'b1;
         target           = ex_entry;
      end else if (is_ertn) begin
         event_oh[EV_ERTN] = 1'b1;
         redirect          = 1'b1;
         target            = ertn_entry;
      end else if (csr_wr) begin
         event_oh[EV_CSR] = 1'b1;
         if (REFETCH_ON_CSR && is_refetch_csr(csr_num)) begin
            redirect = 1'b1;
            target   = pc + 32'd4;
         end else begin
            redirect = 1'b0;
            target   = 32'd0;
         end
      end else begin
         event_oh[EV_PLAIN] = 1'b1;
      end
   end

endmodule

// File: rtl/csr_commit_ctrl.sv
// Writeback commit controller: owns CSR writes, commits exceptions/ertn to csr,
// flushes the pipeline and holds a redirect to pre-IF until it is accepted.
module csr_commit_ctrl
   import csr_commit_ctrl_pkg::*;
#(
   parameter bit REFETCH_ON_CSR = 1'b1
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        wb_valid,
   input  logic [31:0] wb_pc_in,
   input  logic        wb_ex_req,
   input  logic [5:0]  wb_ecode_in,
   input  logic [8:0]  wb_esubcode_in,
   input  logic [31:0] wb_vaddr_in,
   input  logic        wb_is_ertn,
   input  logic        wb_csr_wr,
   input  logic [13:0] wb_csr_num,
   input  logic [31:0] wb_csr_wmask,
   input  logic [31:0] wb_csr_wvalue,
   input  logic        has_int,
   input  logic [31:0] ex_entry,
   input  logic [31:0] ertn_entry,
   output logic        csr_we,
   output logic [13:0] csr_num,
   output logic [31:0] csr_wmask,
   output logic [31:0] csr_wvalue,
   output logic        wb_ex,
   output logic [5:0]  wb_ecode,
   output logic [8:0]  wb_esubcode,
   output logic [31:0] wb_vaddr,
   output logic [31:0] wb_pc,
   output logic        ertn_flush,
   output logic        flush,
   output logic        redirect_valid,
   output logic [31:0] redirect_pc,
   input  logic        redirect_ready,
   output logic        commit
);

   cc_state_e        state_r;
   logic             active_s;
   logic [EV_W-1:0]  event_s;
   logic             redir_s;
   logic [31:0]      target_s;

   // resetn gates the commit cycle so no CSR side effect can escape during reset.
   assign active_s = resetn & wb_valid & (state_r == ST_RUN);

   commit_prio #(
      .REFETCH_ON_CSR (REFETCH_ON_CSR)
   ) u_prio (
      .active     (active_s),
      .has_int    (has_int),
      .ex_req     (wb_ex_req),
      .is_ertn    (wb_is_ertn),
      .csr_wr     (wb_csr_wr),
      .csr_num    (wb_csr_num),
      .pc         (wb_pc_in),
      .ex_entry   (ex_entry),
      .ertn_entry (ertn_entry),
      .event_oh   (event_s),
      .redirect   (redir_s),
      .target     (target_s)
   );

   // Commit-cycle outputs toward csr and the pipeline, decoded from the selected event.
   always_comb begin
      csr_we      = 1'b0;
      csr_num     = 14'd0;
      csr_wmask   = 32'd0;
      csr_wvalue  = 32'd0;
      wb_ex       = 1'b0;
      wb_ecode    = 6'd0;
      wb_esubcode = 9'd0;
      wb_vaddr    = 32'd0;
      wb_pc       = 32'd0;
      ertn_flush  = 1'b0;
      commit      = 1'b0;
      flush       = redir_s;
      if (event_s[EV_INT]) begin
         wb_ex       = 1'b1;
         wb_ecode    = ECODE_INT;
         wb_esubcode = 9'd0;
         wb_pc       = wb_pc_in;
      end else if (event_s[EV_EXC]) begin
         wb_ex       = 1'b1;
         wb_ecode    = wb_ecode_in;
         wb_esubcode = wb_esubcode_in;
         wb_vaddr    = wb_vaddr_in;
         wb_pc       = wb_pc_in;
      end else if (event_s[EV_ERTN]) begin
         ertn_flush = 1'b1;
      end else if (event_s[EV_CSR]) begin
         csr_we     = 1'b1;
         csr_num    = wb_csr_num;
         csr_wmask  = wb_csr_wmask;
         csr_wvalue = wb_csr_wvalue;
         commit     = 1'b1;
      end else if (event_s[EV_PLAIN]) begin
         commit = 1'b1;
      end else begin
         commit = 1'b0;
      end
   end

   // RUN/REDIR state with the registered redirect request.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_r        <= ST_RUN;
         redirect_valid <= 1'b0;
         redirect_pc    <= 32'd0;
      end else begin
         case (state_r)
            ST_RUN: begin
               if (redir_s) begin
                  state_r        <= ST_REDIR;
                  redirect_valid <= 1'b1;
                  redirect_pc    <= target_s;
               end else begin
                  state_r        <= ST_RUN;
                  redirect_valid <= 1'b0;
               end
            end
            ST_REDIR: begin
               if (redirect_ready) begin
                  state_r        <= ST_RUN;
                  redirect_valid <= 1'b0;
               end else begin
                  state_r        <= ST_REDIR;
                  redirect_valid <= 1'b1;
               end
            end
            default: begin
               state_r        <= ST_RUN;
               redirect_valid <= 1'b0;
            end
         endcase
      end
   end

   csr_commit_ctrl_chk u_chk (
      .clk            (clk),
      .resetn         (resetn),
      .csr_we         (csr_we),
      .wb_ex          (wb_ex),
      .ertn_flush     (ertn_flush),
      .commit         (commit),
      .flush          (flush),
      .redirect_valid (redirect_valid),
      .redirect_ready (redirect_ready),
      .redirect_pc    (redirect_pc)
   );

endmodule

// File: tb/tb_csr_commit_ctrl.sv
// Bench for csr_commit_ctrl: directed scenarios then random traffic, two instances
// (refetch on / off) checked every cycle against a behavioural model.
module tb_csr_commit_ctrl;

   logic        clk;
   logic        resetn;
   logic        wb_valid;
   logic [31:0] wb_pc_in;
   logic        wb_ex_req;
   logic [5:0]  wb_ecode_in;
   logic [8:0]  wb_esubcode_in;
   logic [31:0] wb_vaddr_in;
   logic        wb_is_ertn;
   logic        wb_csr_wr;
   logic [13:0] wb_csr_num;
   logic [31:0] wb_csr_wmask;
   logic [31:0] wb_csr_wvalue;
   logic        has_int;
   logic [31:0] ex_entry;
   logic [31:0] ertn_entry;
   logic        redirect_ready;

   // Packed view of every output of one instance (plus the next redirect target for the model).
   typedef struct packed {
      logic        csr_we;
      logic [13:0] num;
      logic [31:0] wmask;
      logic [31:0] wvalue;
      logic        wb_ex;
      logic [5:0]  ecode;
      logic [8:0]  esub;
      logic [31:0] vaddr;
      logic [31:0] wbpc;
      logic        ertn;
      logic        flush;
      logic        commit;
      logic        rv;
      logic [31:0] rpc;
      logic [31:0] next_tgt;
   } obs_t;

   obs_t o1, o0;

   csr_commit_ctrl #(.REFETCH_ON_CSR(1'b1)) dut (
      .clk(clk), .resetn(resetn), .wb_valid(wb_valid), .wb_pc_in(wb_pc_in),
      .wb_ex_req(wb_ex_req), .wb_ecode_in(wb_ecode_in), .wb_esubcode_in(wb_esubcode_in),
      .wb_vaddr_in(wb_vaddr_in), .wb_is_ertn(wb_is_ertn), .wb_csr_wr(wb_csr_wr),
      .wb_csr_num(wb_csr_num), .wb_csr_wmask(wb_csr_wmask), .wb_csr_wvalue(wb_csr_wvalue),
      .has_int(has_int), .ex_entry(ex_entry), .ertn_entry(ertn_entry),
      .csr_we(o1.csr_we), .csr_num(o1.num), .csr_wmask(o1.wmask), .csr_wvalue(o1.wvalue),
      .wb_ex(o1.wb_ex), .wb_ecode(o1.ecode), .wb_esubcode(o1.esub), .wb_vaddr(o1.vaddr),
      .wb_pc(o1.wbpc), .ertn_flush(o1.ertn), .flush(o1.flush),
      .redirect_valid(o1.rv), .redirect_pc(o1.rpc), .redirect_ready(redirect_ready),
      .commit(o1.commit)
   );

   csr_commit_ctrl #(.REFETCH_ON_CSR(1'b0)) dut_norefetch (
      .clk(clk), .resetn(resetn), .wb_valid(wb_valid), .wb_pc_in(wb_pc_in),
      .wb_ex_req(wb_ex_req), .wb_ecode_in(wb_ecode_in), .wb_esubcode_in(wb_esubcode_in),
      .wb_vaddr_in(wb_vaddr_in), .wb_is_ertn(wb_is_ertn), .wb_csr_wr(wb_csr_wr),
      .wb_csr_num(wb_csr_num), .wb_csr_wmask(wb_csr_wmask), .wb_csr_wvalue(wb_csr_wvalue),
      .has_int(has_int), .ex_entry(ex_entry), .ertn_entry(ertn_entry),
      .csr_we(o0.csr_we), .csr_num(o0.num), .csr_wmask(o0.wmask), .csr_wvalue(o0.wvalue),
      .wb_ex(o0.wb_ex), .wb_ecode(o0.ecode), .wb_esubcode(o0.esub), .wb_vaddr(o0.vaddr),
      .wb_pc(o0.wbpc), .ertn_flush(o0.ertn), .flush(o0.flush),
      .redirect_valid(o0.rv), .redirect_pc(o0.rpc), .redirect_ready(redirect_ready),
      .commit(o0.commit)
   );

   assign o1.next_tgt = 32'd0;
   assign o0.next_tgt = 32'd0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int   n_assert = 0;
   int   n_fail   = 0;
   logic pend [2];
   logic [31:0] tgt [2];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic refetch_num(input logic [13:0] n);
      return (n == 14'h000) || (n == 14'h004) || (n == 14'h005) || (n == 14'h044);
   endfunction

   // What an instance with refetch setting rf must show for the current inputs.
   function automatic obs_t model(input int rf);
      obs_t e;
      e = '0;
      e.rv  = pend[rf];
      e.rpc = tgt[rf];
      if (resetn && wb_valid && !pend[rf]) begin
         if (has_int) begin
            e.wb_ex = 1'b1; e.wbpc = wb_pc_in; e.flush = 1'b1; e.next_tgt = ex_entry;
         end else if (wb_ex_req) begin
            e.wb_ex = 1'b1; e.ecode = wb_ecode_in; e.esub = wb_esubcode_in;
            e.vaddr = wb_vaddr_in; e.wbpc = wb_pc_in; e.flush = 1'b1; e.next_tgt = ex_entry;
         end else if (wb_is_ertn) begin
            e.ertn = 1'b1; e.flush = 1'b1; e.next_tgt = ertn_entry;
         end else begin
            e.commit = 1'b1;
            if (wb_csr_wr) begin
               e.csr_we = 1'b1; e.num = wb_csr_num; e.wmask = wb_csr_wmask; e.wvalue = wb_csr_wvalue;
               e.flush = (rf == 1) && refetch_num(wb_csr_num);
               e.next_tgt = wb_pc_in + 32'd4;
            end
         end
      end
      return e;
   endfunction

   task automatic cmp(input string ph, input string d, input obs_t a, input obs_t e);
      chk({ph, d, ".csr_we"}, {31'd0, a.csr_we}, {31'd0, e.csr_we});
      chk({ph, d, ".csr_num"}, {18'd0, a.num}, {18'd0, e.num});
      chk({ph, d, ".csr_wmask"}, a.wmask, e.wmask);
      chk({ph, d, ".csr_wvalue"}, a.wvalue, e.wvalue);
      chk({ph, d, ".wb_ex"}, {31'd0, a.wb_ex}, {31'd0, e.wb_ex});
      chk({ph, d, ".wb_ecode"}, {26'd0, a.ecode}, {26'd0, e.ecode});
      chk({ph, d, ".wb_esubcode"}, {23'd0, a.esub}, {23'd0, e.esub});
      chk({ph, d, ".wb_vaddr"}, a.vaddr, e.vaddr);
      chk({ph, d, ".wb_pc"}, a.wbpc, e.wbpc);
      chk({ph, d, ".ertn_flush"}, {31'd0, a.ertn}, {31'd0, e.ertn});
      chk({ph, d, ".flush"}, {31'd0, a.flush}, {31'd0, e.flush});
      chk({ph, d, ".commit"}, {31'd0, a.commit}, {31'd0, e.commit});
      chk({ph, d, ".redirect_valid"}, {31'd0, a.rv}, {31'd0, e.rv});
      chk({ph, d, ".redirect_pc"}, a.rpc, e.rpc);
   endtask

   obs_t e1, e0;

   // Let inputs settle, then compare both instances against the model.
   task automatic settle(input string ph);
      #1;
      e1 = model(1);
      e0 = model(0);
      cmp(ph, ".rf1", o1, e1);
      cmp(ph, ".rf0", o0, e0);
   endtask

   // Clock edge, then advance the model's redirect bookkeeping.
   task automatic tick();
      @(posedge clk);
      for (int rf = 0; rf < 2; rf++) begin
         obs_t e;
         e = (rf == 1) ? e1 : e0;
         if (!resetn) begin
            pend[rf] = 1'b0; tgt[rf] = 32'd0;
         end else if (pend[rf]) begin
            if (redirect_ready) pend[rf] = 1'b0;
         end else if (e.flush) begin
            pend[rf] = 1'b1; tgt[rf] = e.next_tgt;
         end
      end
      #1;
   endtask

   task automatic cycle(input string ph);
      settle(ph);
      tick();
   endtask

   task automatic idle_inputs();
      wb_valid = 1'b0; wb_pc_in = 32'd0; wb_ex_req = 1'b0; wb_ecode_in = 6'd0;
      wb_esubcode_in = 9'd0; wb_vaddr_in = 32'd0; wb_is_ertn = 1'b0; wb_csr_wr = 1'b0;
      wb_csr_num = 14'd0; wb_csr_wmask = 32'd0; wb_csr_wvalue = 32'd0; has_int = 1'b0;
      redirect_ready = 1'b0;
   endtask

   initial begin
      for (int rf = 0; rf < 2; rf++) begin pend[rf] = 1'b0; tgt[rf] = 32'd0; end
      idle_inputs();
      ex_entry = 32'h1C008000;
      ertn_entry = 32'h1C000404;
      resetn = 1'b0;

      // Reset: a valid CSR write must not leak out while resetn is low.
      wb_valid = 1'b1; wb_csr_wr = 1'b1; wb_csr_num = 14'h000; wb_csr_wmask = 32'hFFFFFFFF;
      settle("reset");
      chk("reset.csr_we", {31'd0, o1.csr_we}, 32'd0);
      chk("reset.redirect_valid", {31'd0, o1.rv}, 32'd0);
      tick(); tick();
      idle_inputs();
      resetn = 1'b1;
      cycle("idle");

      // Plain CSR write to SAVE0.
      wb_valid = 1'b1; wb_pc_in = 32'h1C000100; wb_csr_wr = 1'b1; wb_csr_num = 14'h030;
      wb_csr_wmask = 32'hFFFFFFFF; wb_csr_wvalue = 32'h00001234;
      settle("save0");
      chk("save0.csr_we", {31'd0, o1.csr_we}, 32'd1);
      chk("save0.commit", {31'd0, o1.commit}, 32'd1);
      chk("save0.flush", {31'd0, o1.flush}, 32'd0);
      tick();
      idle_inputs();
      settle("save0_after");
      chk("save0_after.csr_we", {31'd0, o1.csr_we}, 32'd0);
      chk("save0_after.redirect_valid", {31'd0, o1.rv}, 32'd0);
      tick();

      // Instruction exception, redirect held while not ready.
      wb_valid = 1'b1; wb_pc_in = 32'h1C000200; wb_ex_req = 1'b1; wb_ecode_in = 6'h0B;
      settle("exc");
      chk("exc.wb_pc", o1.wbpc, 32'h1C000200);
      chk("exc.flush", {31'd0, o1.flush}, 32'd1);
      tick();
      idle_inputs();
      for (int i = 0; i < 3; i++) begin
         settle("exc_hold");
         chk("exc_hold.redirect_valid", {31'd0, o1.rv}, 32'd1);
         chk("exc_hold.redirect_pc", o1.rpc, 32'h1C008000);
         tick();
      end
      redirect_ready = 1'b1;
      wb_valid = 1'b1; wb_csr_wr = 1'b1; wb_csr_num = 14'h030;
      cycle("exc_accept");
      idle_inputs();
      settle("exc_done");
      chk("exc_done.redirect_valid", {31'd0, o1.rv}, 32'd0);
      tick();

      // Interrupt beats a CSR write and an exception on the same instruction.
      wb_valid = 1'b1; has_int = 1'b1; wb_csr_wr = 1'b1; wb_csr_num = 14'h030;
      wb_ex_req = 1'b1; wb_ecode_in = 6'h09; wb_pc_in = 32'h1C000300; wb_vaddr_in = 32'hDEAD0000;
      settle("int");
      chk("int.wb_ex", {31'd0, o1.wb_ex}, 32'd1);
      chk("int.wb_ecode", {26'd0, o1.ecode}, 32'd0);
      chk("int.csr_we", {31'd0, o1.csr_we}, 32'd0);
      chk("int.commit", {31'd0, o1.commit}, 32'd0);
      tick();
      idle_inputs(); redirect_ready = 1'b1;
      cycle("int_accept");
      idle_inputs();

      // ertn, then an interrupted instruction during REDIR is silently dropped.
      wb_valid = 1'b1; wb_is_ertn = 1'b1; wb_pc_in = 32'h1C000400;
      settle("ertn");
      chk("ertn.ertn_flush", {31'd0, o1.ertn}, 32'd1);
      tick();
      wb_is_ertn = 1'b0; has_int = 1'b1; wb_csr_wr = 1'b1;
      settle("ertn_redir");
      chk("ertn_redir.redirect_pc", o1.rpc, 32'h1C000404);
      chk("ertn_redir.wb_ex", {31'd0, o1.wb_ex}, 32'd0);
      tick();
      idle_inputs(); redirect_ready = 1'b1;
      cycle("ertn_accept");
      idle_inputs();

      // CRMD write at the top of the address space: refetch target wraps.
      wb_valid = 1'b1; wb_pc_in = 32'hFFFFFFFC; wb_csr_wr = 1'b1; wb_csr_num = 14'h000;
      wb_csr_wmask = 32'h00000007; wb_csr_wvalue = 32'h00000008;
      settle("crmd");
      chk("crmd.rf1.csr_we", {31'd0, o1.csr_we}, 32'd1);
      chk("crmd.rf1.flush", {31'd0, o1.flush}, 32'd1);
      chk("crmd.rf0.flush", {31'd0, o0.flush}, 32'd0);
      tick();
      idle_inputs();
      settle("crmd_redir");
      chk("crmd_redir.redirect_valid", {31'd0, o1.rv}, 32'd1);
      chk("crmd_redir.redirect_pc", o1.rpc, 32'h00000000);
      chk("crmd_redir.rf0.redirect_valid", {31'd0, o0.rv}, 32'd0);
      tick();

      // Asynchronous reset while a redirect is outstanding.
      #2;
      resetn = 1'b0;
      #1;
      chk("async_rst.redirect_valid", {31'd0, o1.rv}, 32'd0);
      for (int rf = 0; rf < 2; rf++) begin pend[rf] = 1'b0; tgt[rf] = 32'd0; end
      @(posedge clk); #1;
      resetn = 1'b1;
      wb_valid = 1'b1; wb_pc_in = 32'h1C000500;
      settle("post_rst");
      chk("post_rst.commit", {31'd0, o1.commit}, 32'd1);
      tick();
      idle_inputs();

      // Random traffic against the model.
      for (int i = 0; i < 400; i++) begin
         logic [2:0] sel;
         wb_valid       = ($urandom_range(3) != 0);
         has_int        = ($urandom_range(7) == 0);
         wb_ex_req      = ($urandom_range(5) == 0);
         wb_is_ertn     = ($urandom_range(7) == 0);
         wb_csr_wr      = ($urandom_range(2) == 0);
         wb_pc_in       = ($urandom_range(9) == 0) ? 32'hFFFFFFFC : $urandom;
         wb_ecode_in    = 6'($urandom);
         wb_esubcode_in = 9'($urandom);
         wb_vaddr_in    = $urandom;
         wb_csr_wmask   = $urandom;
         wb_csr_wvalue  = $urandom;
         sel            = 3'($urandom_range(7));
         case (sel)
            3'd0:    wb_csr_num = 14'h000;
            3'd1:    wb_csr_num = 14'h004;
            3'd2:    wb_csr_num = 14'h005;
            3'd3:    wb_csr_num = 14'h044;
            3'd4:    wb_csr_num = 14'h006;
            3'd5:    wb_csr_num = 14'h030;
            default: wb_csr_num = 14'($urandom);
         endcase
         ex_entry       = $urandom;
         ertn_entry     = $urandom;
         redirect_ready = ($urandom_range(1) == 0);
         cycle("rand");
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/csr_commit_ctrl.md
# csr_commit_ctrl

Writeback-stage commit controller that owns every write into the `csr` block and turns WB-stage events into pipeline redirects. Each cycle it arbitrates, in fixed priority, among:
- a pending interrupt,
- an instruction exception,
- `ertn`,
- a CSR write,
- a plain commit.

It drives `wb_ex`, `ertn_flush` and the `csr_we` port, pulses a pipeline flush and holds a redirect request to pre-IF until that request is accepted. It sits between the WB stage, `csr` and pre-IF.

## Interface
Parameters:
- REFETCH_ON_CSR, 1, when 1 a CSR write to CRMD/ECFG/ESTAT/TICLR forces a refetch of wb_pc+4.

Ports:
- Clock and reset: one clock; reset is asynchronous and active-low.
  - clk  in  1  clock
  - resetn  in  1  asynchronous active-low reset
- From the WB stage:
  - wb_valid  in  1  WB holds an instruction
  - wb_pc_in  in  32  WB instruction PC
  - wb_ex_req  in  1  instruction carries an exception
  - wb_ecode_in  in  6  exception code
  - wb_esubcode_in  in  9  exception subcode
  - wb_vaddr_in  in  32  faulting address
  - wb_is_ertn  in  1  instruction is ertn
  - wb_csr_wr  in  1  instruction writes a CSR
  - wb_csr_num  in  14  CSR number
  - wb_csr_wmask  in  32  write mask
  - wb_csr_wvalue  in  32  write value
- From csr:
  - has_int  in  1  interrupt pending
  - ex_entry  in  32  exception entry
  - ertn_entry  in  32  return target
- To csr:
  - csr_we  out  1  write enable
  - csr_num  out  14  CSR number
  - csr_wmask  out  32  write mask
  - csr_wvalue  out  32  write value
  - wb_ex  out  1  exception commit
  - wb_ecode  out  6  exception code
  - wb_esubcode  out  9  exception subcode
  - wb_vaddr  out  32  faulting address
  - wb_pc  out  32  PC recorded into ERA
  - ertn_flush  out  1  ertn commit
- To the pipeline:
  - flush  out  1  kill all younger stages
  - redirect_valid  out  1  redirect request to pre-IF
  - redirect_pc  out  32  redirect target
  - redirect_ready  in  1  pre-IF accepts the redirect
- Commit result:
  - commit  out  1  instruction retired normally (including CSR write)

## Operation
- States: RUN and REDIR; reset enters RUN.
- Commit cycle: RUN with wb_valid=1. Exactly one of the following applies, in priority order.
  1. has_int:
     - wb_ex=1, wb_ecode=0x00, wb_esubcode=0, wb_vaddr=0, wb_pc=wb_pc_in.
     - The instruction is not retired and its own exception or CSR write is dropped.
     - Target is ex_entry.
  2. wb_ex_req:
     - wb_ex=1 with wb_ecode_in, wb_esubcode_in, wb_vaddr_in and wb_pc_in passed through.
     - Target is ex_entry.
  3. wb_is_ertn: ertn_flush=1, target ertn_entry.
  4. wb_csr_wr:
     - csr_we=1 with num, wmask and wvalue passed through; commit=1.
     - If REFETCH_ON_CSR=1 and num ∈ {0x00, 0x04, 0x05, 0x44}, target wb_pc_in+4 (32-bit wrap). Otherwise no redirect.
  5. Otherwise: commit=1, no redirect.
- Cases 1–3 and a refetch write are redirect events:
  - flush=1 in the commit cycle.
  - The target is latched into redirect_pc and the state moves to REDIR.
- csr_we, wb_ex and ertn_flush are mutually exclusive and are never asserted outside RUN.
- REDIR:
  - redirect_valid=1 and redirect_pc is held stable.
  - Every wb_valid instruction is discarded: no CSR outputs, no commit, no flush.
  - When redirect_valid & redirect_ready, return to RUN next cycle. wb_valid in that handshake cycle is also discarded.
- has_int is ignored in REDIR and whenever wb_valid=0. An interrupt is taken only on a valid WB instruction.

## Timing
- Commit-cycle outputs are combinational from WB inputs and state: csr_we/num/wmask/wvalue, wb_ex and its fields, ertn_flush, flush, commit. The csr block registers them at the end of that cycle.
- redirect_valid and redirect_pc are registered. redirect_valid rises the cycle after the commit cycle and has a minimum width of 1 cycle. The minimum event-to-next-commit gap is 2 cycles.
- Reset values: redirect_valid=0, redirect_pc=0, state RUN. All combinational outputs are 0 while wb_valid=0.
- resetn assertion mid-REDIR drops redirect_valid immediately (async) and returns to RUN. No CSR output pulses during reset.
- redirect_ready while redirect_valid=0 is ignored.

## Structure
- Shared package (also used by csr):
  - CSR numbers: CRMD, ECFG, ESTAT, TICLR, ERA, EENTRY.
  - ECODE_INT, ECODE_ADE, ECODE_ALE, ESUBCODE_ADEF.
  - State encoding.
- Single module. A combinational event-priority encoder is natural as sub-module `commit_prio`, outputting a one-hot event and the selected target.

## Test plan
- Plain CSR write to SAVE0 (0x30, mask 0xFFFFFFFF, value 0x1234) at pc 0x1C000100 → csr_we=1 for one cycle, commit=1, flush=0, redirect_valid stays 0.
- wb_ex_req with ecode 0x0B, pc 0x1C000200, ex_entry 0x1C008000 → wb_ex=1, wb_pc=0x1C000200, flush=1. Next cycle redirect_valid=1 with redirect_pc=0x1C008000, held 3 cycles with redirect_ready=0, then deasserts the cycle after ready.
- has_int=1 together with a CSR write and wb_ex_req (ecode 0x09) → wb_ex=1 with ecode 0x00, csr_we=0, commit=0.
- ertn with ertn_entry 0x1C000404 → ertn_flush=1 and redirect_pc=0x1C000404. wb_valid with has_int=1 during REDIR produces no outputs.
- CSR write to CRMD at pc 0xFFFFFFFC → csr_we=1 and redirect_pc=0x00000000 (wrap). With REFETCH_ON_CSR=0 there is no flush.
- resetn pulled low while redirect_valid=1 → redirect_valid=0 without a clock edge. After release, a plain instruction commits normally.
